// File: rtl/array_swap_seq.sv
// array_swap_seq: swaps two equal-length u32 word ranges of the execution
// environment through a single granted read/write memory port.
// Build option: define ARRAY_SWAP_SEQ_OVERLAP_CHECK_EN to reject requests whose
// two ranges intersect; without it overlapping ranges are swapped word by word
// in ascending index order.
module array_swap_seq #(
  parameter int ADDR_W = 6,
  parameter int EV_LEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_arr_1,
  input  logic [ADDR_W-1:0] req_arr_2,
  input  logic [ADDR_W:0]   req_length,
  input  logic              req_cond_ok,
  input  logic              mem_gnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              done,
  output logic              err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] arr_1_q, arr_2_q;
  logic [ADDR_W:0]   len_q, i_q, i_nx;
  logic [31:0]       tmp_a, rd_hold, rd_word;
  logic              hold_v, err_q;
  logic              accept, last_word;
  logic              req_noop, req_bad;
  logic [ADDR_W+1:0] end_1, end_2, ev_len_w;

  assign accept    = req_valid && (state == IDLE);
  assign i_nx      = i_q + (ADDR_W+1)'(1);
  assign last_word = (i_nx == len_q);
  // The read word is only presented for one cycle after a granted read; once a
  // stall has parked it in rd_hold, the parked copy is used instead.
  assign rd_word   = hold_v ? rd_hold : rd_data;

  // Classify an incoming request: no-op, rejected, or a real swap.
  always_comb begin
    ev_len_w = (ADDR_W+2)'(EV_LEN);
    end_1    = {2'b00, req_arr_1} + {1'b0, req_length};
    end_2    = {2'b00, req_arr_2} + {1'b0, req_length};
    req_noop = !req_cond_ok || (req_length == '0) || (req_arr_1 == req_arr_2);
    req_bad  = (end_1 > ev_len_w) || (end_2 > ev_len_w);
`ifdef ARRAY_SWAP_SEQ_OVERLAP_CHECK_EN
    if (({2'b00, req_arr_1} < end_2) && ({2'b00, req_arr_2} < end_1))
      req_bad = 1'b1;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; every memory phase waits for a grant.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = (req_noop || req_bad) ? DONE : RD_A;
      RD_A: if (mem_gnt) state_nx = RD_B;
      RD_B: if (mem_gnt) state_nx = WR_A;
      WR_A: if (mem_gnt) state_nx = WR_B;
      WR_B: if (mem_gnt) state_nx = last_word ? DONE : RD_A;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Argument latch, word index, captured array-1 word and stall hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_1_q <= '0;
      arr_2_q <= '0;
      len_q   <= '0;
      i_q     <= '0;
      tmp_a   <= '0;
      rd_hold <= '0;
      hold_v  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        arr_1_q <= req_arr_1;
        arr_2_q <= req_arr_2;
        len_q   <= req_length;
        i_q     <= '0;
        err_q   <= !req_noop && req_bad;
        hold_v  <= 1'b0;
      end
      unique case (state)
        RD_B, WR_A: begin
          if (mem_gnt) begin
            hold_v <= 1'b0;
            if (state == RD_B) tmp_a <= rd_word;
          end else if (!hold_v) begin
            rd_hold <= rd_data;
            hold_v  <= 1'b1;
          end
        end
        WR_B: if (mem_gnt) i_q <= i_nx;
        default: ;
      endcase
    end
  end

  // Output decode from the current state.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    err       = (state == DONE) && err_q;
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    unique case (state)
      RD_A: begin
        rd_en   = 1'b1;
        rd_addr = arr_1_q + i_q[ADDR_W-1:0];
      end
      RD_B: begin
        rd_en   = 1'b1;
        rd_addr = arr_2_q + i_q[ADDR_W-1:0];
      end
      WR_A: begin
        wr_en   = 1'b1;
        wr_addr = arr_1_q + i_q[ADDR_W-1:0];
        wr_data = rd_word;
      end
      WR_B: begin
        wr_en   = 1'b1;
        wr_addr = arr_2_q + i_q[ADDR_W-1:0];
        wr_data = tmp_a;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_array_swap_seq.sv
// Self-checking bench for array_swap_seq: memory responder with garbage read
// data on ungranted cycles, plus a plain array reference of the swap result.
module tb_array_swap_seq;

  localparam int ADDR_W = 6;
  localparam int EV_LEN = 64;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_arr_1;
  logic [ADDR_W-1:0] req_arr_2;
  logic [ADDR_W:0]   req_length;
  logic              req_cond_ok;
  logic              mem_gnt;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              done;
  logic              err;
  logic              busy;

  int checks = 0;
  int errors = 0;

  array_swap_seq #(.ADDR_W(ADDR_W), .EV_LEN(EV_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_arr_1(req_arr_1), .req_arr_2(req_arr_2),
    .req_length(req_length), .req_cond_ok(req_cond_ok),
    .mem_gnt(mem_gnt),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: granted read returns data next cycle, otherwise garbage.
  logic [31:0] mem   [EV_LEN];
  logic [31:0] ref_m [EV_LEN];
  logic        do_init = 1'b0;
  logic [31:0] init_seed = '0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;

  always @(posedge clk) begin
    if (do_init) begin
      for (int k = 0; k < EV_LEN; k++) mem[k] <= init_seed ^ (32'(k) * 32'h9E3779B1);
    end else if (wr_en && mem_gnt) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en && mem_gnt) rd_data <= mem[rd_addr];
    else                  rd_data <= $urandom;
    if (rd_en && mem_gnt) rd_cnt <= rd_cnt + 1;
    if (wr_en && mem_gnt) wr_cnt <= wr_cnt + 1;
    if (rd_en && wr_en)   both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic init_mem(input logic [31:0] seed);
    @(negedge clk);
    init_seed = seed;
    do_init   = 1'b1;
    @(negedge clk);
    do_init   = 1'b0;
    for (int k = 0; k < EV_LEN; k++) ref_m[k] = seed ^ (32'(k) * 32'h9E3779B1);
  endtask

  // 0 = no-op, 1 = rejected, 2 = swap performed.
  function automatic int expect_kind(input int a1, input int a2, input int len, input bit cond);
    if (!cond || len == 0 || a1 == a2) return 0;
    if (a1 + len > EV_LEN || a2 + len > EV_LEN) return 1;
`ifdef ARRAY_SWAP_SEQ_OVERLAP_CHECK_EN
    if (a1 < a2 + len && a2 < a1 + len) return 1;
`endif
    return 2;
  endfunction

  task automatic compare_mem(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < EV_LEN; k++) if (mem[k] !== ref_m[k]) bad++;
    check({tag, "_mem"}, 64'(bad), 64'd0);
  endtask

  // mode 0: grant always; 1: random grant; 2: 3-cycle stall in WR_A of word 1.
  task automatic run_req(input string tag, input int a1, input int a2, input int len,
                         input bit cond, input int mode);
    int kind, rd0, wr0, both0, cyc, stalls, exp_lat, err_out;
    logic [31:0] stall_word, tmp;
    kind = expect_kind(a1, a2, len, cond);
    stalls = 0;
    err_out = 0;
    stall_word = '0;
    @(negedge clk);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid   = 1'b1;
    req_arr_1   = ADDR_W'(a1);
    req_arr_2   = ADDR_W'(a2);
    req_length  = (ADDR_W+1)'(len);
    req_cond_ok = cond;
    mem_gnt     = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt; both0 = both_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc <= 2000) begin
      if (err !== 1'b0) err_out++;
      if (mode == 1) begin
        mem_gnt = ($urandom % 4) != 0;
      end else if (mode == 2 && wr_en && wr_addr == ADDR_W'(a1 + 1) && stalls < 3) begin
        mem_gnt = 1'b0;
        if (stalls == 0) begin
          stall_word = wr_data;
          check({tag, "_stall_wdata"}, 64'(wr_data), 64'(ref_m[a2 + 1]));
        end else begin
          check({tag, "_stall_stable"}, 64'(wr_data), 64'(stall_word));
        end
        stalls++;
      end else begin
        mem_gnt = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    mem_gnt = 1'b1;
    if (cyc > 2000) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      exp_lat = (kind == 2) ? 4 * len + 1 : 1;
      if (mode == 2) exp_lat += 3;
      if (mode != 1) check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
      if (mode == 2) check({tag, "_stalls"}, 64'(stalls), 64'd3);
      check({tag, "_err"}, 64'(err), 64'(kind == 1));
      check({tag, "_err_early"}, 64'(err_out), 64'd0);
      @(negedge clk);
      check({tag, "_pulse"}, {62'd0, done, err}, 64'd0);
      check({tag, "_idle"}, 64'(req_ready), 64'd1);
      if (kind == 2) begin
        for (int k = 0; k < len; k++) begin
          tmp = ref_m[a1 + k];
          ref_m[a1 + k] = ref_m[a2 + k];
          ref_m[a2 + k] = tmp;
        end
      end
      compare_mem(tag);
      check({tag, "_rd_cnt"}, 64'(rd_cnt - rd0), 64'((kind == 2) ? 2 * len : 0));
      check({tag, "_wr_cnt"}, 64'(wr_cnt - wr0), 64'((kind == 2) ? 2 * len : 0));
      check({tag, "_rdwr_excl"}, 64'(both_cnt - both0), 64'd0);
    end
  endtask

  initial begin
    int cyc, a1, a2, len;
    logic [31:0] tmp;
    rst_n = 1'b0; req_valid = 1'b0; req_arr_1 = '0; req_arr_2 = '0;
    req_length = '0; req_cond_ok = 1'b0; mem_gnt = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {req_ready, busy, done, err, rd_en, wr_en}, 64'b100000);
    rst_n = 1'b1;

    init_mem(32'h1234_5678);
    run_req("swap3", 0, 8, 3, 1'b1, 0);
    init_mem(32'hCAFE_0001);
    run_req("stall3", 0, 8, 3, 1'b1, 2);
    run_req("cond0", 0, 8, 3, 1'b0, 0);
    run_req("len0", 0, 8, 0, 1'b1, 0);
    run_req("same5", 5, 5, 4, 1'b1, 0);
    run_req("oob60", 60, 0, 5, 1'b1, 0);
    run_req("overlap", 0, 2, 4, 1'b1, 0);
    run_req("edge_fit", 56, 0, 8, 1'b1, 0);
    run_req("edge_oob", 57, 0, 8, 1'b1, 0);

    // Reset during RD_B of word 1: word 0 swapped, word 1 untouched.
    init_mem(32'h0BAD_F00D);
    @(negedge clk);
    req_valid = 1'b1; req_arr_1 = 6'd0; req_arr_2 = 6'd8; req_length = 7'd3;
    req_cond_ok = 1'b1; mem_gnt = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!(rd_en && rd_addr == 6'd9) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_find_rdb1", 64'(cyc < 100), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {req_ready, busy, done, err, rd_en, wr_en}, 64'b100000);
    check("rst_mid_addr", {rd_addr, wr_addr}, 64'd0);
    check("rst_mid_wdata", 64'(wr_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_after", {req_ready, busy}, 64'b10);
    tmp = ref_m[0]; ref_m[0] = ref_m[8]; ref_m[8] = tmp;
    compare_mem("rst_partial");

    // Randomized requests under random grant.
    init_mem($urandom);
    for (int n = 0; n < 24; n++) begin
      a1  = $urandom_range(0, EV_LEN - 1);
      a2  = $urandom_range(0, EV_LEN - 1);
      len = $urandom_range(0, 12);
      if (n % 3 == 0 && a1 + len > EV_LEN) a1 = EV_LEN - len;
      if (n % 3 == 0 && a2 + len > EV_LEN) a2 = EV_LEN - len;
      run_req($sformatf("rand%0d", n), a1, a2, len, ($urandom % 8) != 0, (n % 2 == 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_swap_seq.md
ARRAY_SWAP_SEQ -- requirements
Module: array_swap_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, the word-address width of the execution-environment u32 array.
REQ-002 SHALL have parameter EV_LEN, default 64, the number of u32 words in the execution environment.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  swap request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_arr_1 / req_arr_2  input  ADDR_W each  base word addresses of the two arrays.
REQ-008 SHALL have port req_length  input  ADDR_W+1  number of words to swap.
REQ-009 SHALL have port req_cond_ok  input  1  pre-evaluated conditional flag; 0 makes the request a no-op.
REQ-010 SHALL have port mem_gnt  input  1  memory port granted this cycle.
REQ-011 SHALL have port rd_en / rd_addr  output  1 / ADDR_W  read request; read data returns one cycle later.
REQ-012 SHALL have port rd_data  input  32  read data for the previous granted read.
REQ-013 SHALL have port wr_en / wr_addr / wr_data  output  1 / ADDR_W / 32  write request.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port err  output  1  status valid with done; 1 = request rejected, no writes performed.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, RD_A, RD_B, WR_A, WR_B, DONE; req_ready=1 only in IDLE.
REQ-018 On req_valid&req_ready SHALL latch arguments, clear word index i, and go to DONE (err=0) if req_cond_ok=0, req_length=0 or arr_1==arr_2; to DONE (err=1) if arr_1+length>EV_LEN or arr_2+length>EV_LEN (computed at ADDR_W+2 bits, no wrap); otherwise to RD_A.
REQ-019 RD_A SHALL drive rd_en=1, rd_addr=arr_1+i; RD_B SHALL drive rd_en=1, rd_addr=arr_2+i and capture rd_data into tmp_a.
REQ-020 WR_A SHALL drive wr_en=1, wr_addr=arr_1+i, wr_data=rd_data (array-2 word); WR_B SHALL drive wr_en=1, wr_addr=arr_2+i, wr_data=tmp_a.
REQ-021 WR_B SHALL increment i and go to DONE when i+1==length, else to RD_A.
REQ-022 Each of RD_A/RD_B/WR_A/WR_B SHALL advance only when mem_gnt=1; with mem_gnt=0 SHALL hold state, address, data and enables unchanged, and SHALL not capture rd_data.
REQ-023 In WR_A a stall SHALL hold the array-2 word in an internal register so wr_data stays stable.
REQ-024 With mem_gnt constantly 1, done SHALL assert exactly 4*length+1 cycles after the accept cycle; no-op/error requests SHALL assert done 1 cycle after accept.
REQ-025 DONE SHALL assert done=1 for one cycle, hold err, and return to IDLE; err SHALL be 0 outside DONE.
REQ-026 rd_en and wr_en SHALL never both be 1 in one cycle; no access SHALL be issued in IDLE or DONE.

Reset
REQ-027 Asserting rst_n=0 at any time, including mid-swap, SHALL force IDLE immediately and drive req_ready=1, busy=0, done=0, err=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0; a partially completed swap is abandoned and not resumed.

Configuration
REQ-028 Macro ARRAY_SWAP_SEQ_OVERLAP_CHECK_EN: when defined, SHALL additionally reject (err=1, no writes) any request whose ranges [arr_1, arr_1+length) and [arr_2, arr_2+length) intersect and arr_1!=arr_2; when undefined, overlapping requests SHALL be executed word-by-word in ascending i with no check.

Verification
REQ-029 arr_1=0, arr_2=8, length=3, cond_ok=1, mem_gnt=1, mem[0..2]=A0..A2, mem[8..10]=B0..B2 -> mem[0..2]=B0..B2, mem[8..10]=A0..A2, done at cycle 13 after accept, err=0.
REQ-030 Same request with mem_gnt low for 3 cycles during WR_A of word 1 -> identical final memory, done at cycle 16, wr_data stable during stall.
REQ-031 cond_ok=0 or length=0 or arr_1=arr_2=5 -> no rd_en/wr_en, done 1 cycle after accept, err=0.
REQ-032 arr_1=60, arr_2=0, length=5 -> err=1 with done 1 cycle after accept, no writes.
REQ-033 arr_1=0, arr_2=2, length=4 -> with ARRAY_SWAP_SEQ_OVERLAP_CHECK_EN err=1 and no writes; without it 16 accesses complete, err=0.
REQ-034 rst_n pulsed low during RD_B of word 1 -> outputs take reset values immediately, req_ready=1 after release, word 0 stays swapped, word 1 untouched.
